// File: rtl/mod_k_down_counter.sv
// Loadable modulo-k down-counter/timer: counts a reload value down to 0 and pulses tc.
// Define MOD_K_DOWN_COUNTER_AUTO_RELOAD_EN to free-run (reload and stay in RUN) instead of one-shot.
module mod_k_down_counter #(
   parameter int unsigned n = 8,
   parameter int unsigned k = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic         pause,
   input  logic         load,
   input  logic [n-1:0] load_val,
   output logic [n-1:0] Q,
   output logic         tc,
   output logic         busy,
   output logic         done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [n-1:0] ReloadDefault = n'(k - 1);

   logic [1:0]   state_q, state_d;
   logic [n-1:0] reload_q, reload_d;
   logic [n-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   logic [n-1:0] load_clamped;

   // Both operands are n bits, so k = 2^n (all-ones reload) never clamps.
   assign load_clamped = (load_val > ReloadDefault) ? ReloadDefault : load_val;

   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      count_d  = count_q;
      tc_d     = 1'b0;
      if (load) begin
         reload_d = load_clamped;
         count_d  = load_clamped;
         state_d  = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) state_d = StRun;
            end
            StRun: begin
               if (!pause) begin
                  if (count_q != '0) begin
                     count_d = count_q - 1'b1;
                  end else begin
                     count_d = reload_q;
                     tc_d    = 1'b1;
`ifdef MOD_K_DOWN_COUNTER_AUTO_RELOAD_EN
                     state_d = StRun;
`else
                     state_d = StDone;
`endif
                  end
               end
            end
            StDone: begin
               count_d = reload_q;
               if (start) state_d = StRun;
            end
            default: begin
               state_d = StIdle;
               count_d = reload_q;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         reload_q <= ReloadDefault;
         count_q  <= ReloadDefault;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         count_q  <= count_d;
         tc_q     <= tc_d;
      end
   end

   assign Q    = count_q;
   assign tc   = tc_q;
   assign busy = (state_q == StRun);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_mod_k_down_counter.sv
// Scoreboard bench for mod_k_down_counter (n=8, k=5): directed vectors with hand-computed
// post-edge outputs are queued by the driver and checked by an independent monitor.
module tb_mod_k_down_counter;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       pause;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] q;
   logic       tc;
   logic       busy;
   logic       done;

   typedef struct {
      logic [7:0]   q;
      logic         tc;
      logic         busy;
      logic         done;
      logic [127:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   mod_k_down_counter #(
      .n(8),
      .k(5)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .pause   (pause),
      .load    (load),
      .load_val(load_val),
      .Q       (q),
      .tc      (tc),
      .busy    (busy),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one edge's inputs on the falling edge and queue the outputs expected after it.
   task automatic step(input logic r, input logic s, input logic p, input logic l,
                       input logic [7:0] lv, input logic [7:0] eq, input logic etc,
                       input logic eb, input logic ed, input logic [127:0] tag);
      exp_t e;
      @(negedge clock);
      reset_n  = r;
      start    = s;
      pause    = p;
      load     = l;
      load_val = lv;
      e.q = eq; e.tc = etc; e.busy = eb; e.done = ed; e.tag = tag;
      sb.push_back(e);
   endtask

   // Monitor: every cycle is an output beat; compare one queued entry per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (q !== e.q || tc !== e.tc || busy !== e.busy || done !== e.done) begin
               n_miss++;
               $display("FAIL %0s: got Q=%0d tc=%b busy=%b done=%b, want Q=%0d tc=%b busy=%b done=%b",
                        e.tag, q, tc, busy, done, e.q, e.tc, e.busy, e.done);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0; load_val = 8'd0;

      // reset and idle hold
      step(0, 0, 0, 0, 8'd0, 8'd4, 0, 0, 0, "reset");
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 0, "idle_hold");

      // basic one-shot: start at edge t, tc at t+5
      step(1, 1, 0, 0, 8'd0, 8'd4, 0, 1, 0, "start");
      step(1, 0, 0, 0, 8'd0, 8'd3, 0, 1, 0, "run_3");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 1, 0, "run_2");
      step(1, 0, 0, 0, 8'd0, 8'd1, 0, 1, 0, "run_1");
      step(1, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "run_0");
      step(1, 0, 0, 0, 8'd0, 8'd4, 1, 0, 1, "terminal");
      step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 1, "tc_drop");
      step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 1, "done_hold");

      // restart from DONE, pause 3 cycles at Q=2, ignored start mid-run
      step(1, 1, 0, 0, 8'd0, 8'd4, 0, 1, 0, "restart");
      step(1, 0, 0, 0, 8'd0, 8'd3, 0, 1, 0, "rs_3");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 1, 0, "rs_2");
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'd0, 8'd2, 0, 1, 0, "pause_hold");
      step(1, 1, 0, 0, 8'd0, 8'd1, 0, 1, 0, "start_ignored");
      step(1, 1, 0, 0, 8'd0, 8'd0, 0, 1, 0, "rs_0");
      step(1, 0, 0, 0, 8'd0, 8'd4, 1, 0, 1, "pause_terminal");
      step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 1, "pause_done");

      // load clamp, custom reload
      step(1, 0, 0, 1, 8'd9, 8'd4, 0, 0, 0, "load_clamp");
      step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 0, "load_idle");
      step(1, 0, 0, 1, 8'd3, 8'd3, 0, 0, 0, "load_3");
      step(1, 1, 0, 0, 8'd0, 8'd3, 0, 1, 0, "l3_start");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 1, 0, "l3_2");
      step(1, 0, 0, 0, 8'd0, 8'd1, 0, 1, 0, "l3_1");
      step(1, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "l3_0");
      step(1, 0, 0, 0, 8'd0, 8'd3, 1, 0, 1, "l3_terminal");

      // reload 0
      step(1, 0, 0, 1, 8'd0, 8'd0, 0, 0, 0, "load_0");
      step(1, 1, 0, 0, 8'd0, 8'd0, 0, 1, 0, "l0_start");
      step(1, 0, 0, 0, 8'd0, 8'd0, 1, 0, 1, "l0_terminal");
      step(1, 0, 0, 0, 8'd0, 8'd0, 0, 0, 1, "l0_done");

      // load beats start, and beats pause/start while running
      step(1, 1, 0, 1, 8'd2, 8'd2, 0, 0, 0, "load_beats_start");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 0, 0, "lbs_idle");
      step(1, 1, 0, 0, 8'd0, 8'd2, 0, 1, 0, "lr_start");
      step(1, 1, 1, 1, 8'd1, 8'd1, 0, 0, 0, "load_in_run");

      // reset mid-run at Q=2 restores the default reload
      step(1, 0, 0, 1, 8'd3, 8'd3, 0, 0, 0, "pre_rst_load");
      step(1, 1, 0, 0, 8'd0, 8'd3, 0, 1, 0, "pre_rst_start");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 1, 0, "pre_rst_2");
      step(0, 1, 0, 0, 8'd0, 8'd4, 0, 0, 0, "mid_reset");
      step(1, 0, 0, 0, 8'd0, 8'd4, 0, 0, 0, "post_rst_idle");
      step(1, 1, 0, 0, 8'd0, 8'd4, 0, 1, 0, "pr_start");
      step(1, 0, 0, 0, 8'd0, 8'd3, 0, 1, 0, "pr_3");
      step(1, 0, 0, 0, 8'd0, 8'd2, 0, 1, 0, "pr_2");
      step(1, 0, 0, 0, 8'd0, 8'd1, 0, 1, 0, "pr_1");
      step(1, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "pr_0");
      step(1, 0, 0, 0, 8'd0, 8'd4, 1, 0, 1, "pr_terminal");

`ifdef MOD_K_DOWN_COUNTER_AUTO_RELOAD_EN
      // free-run with reload 2: tc every 3 cycles, busy stays high
      step(1, 0, 0, 1, 8'd2, 8'd2, 0, 0, 0, "ar_load");
      step(1, 1, 0, 0, 8'd0, 8'd2, 0, 1, 0, "ar_start");
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0, 8'd0, 8'd1, 0, 1, 0, "ar_1");
         step(1, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "ar_0");
         step(1, 0, 0, 0, 8'd0, 8'd2, 1, 1, 0, "ar_tc");
      end
`endif

      // let the monitor drain, bounded
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
      #2;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
